// File: rtl/fft_pkg.sv
// Shared FFT definitions: transform size, address/twiddle widths and the
// scheduler state encoding reused by the butterfly and memory blocks.
package fft_pkg;
    localparam int LOG2N   = 3;
    localparam int N       = 1 << LOG2N;
    localparam int ADDR_W  = LOG2N;
    localparam int TW_W    = LOG2N - 1;
    localparam int STAGE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_TX_PULSE = 3'd3,
        ST_TX_HOLD  = 3'd4,
        ST_TX_WAIT  = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam logic [TW_W-1:0]    J_LAST     = TW_W'(N / 2 - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [ADDR_W-1:0]  K_LAST     = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1'b1);
endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly index) to the in-place operand pair and twiddle
// index of a radix-2 DIT FFT. Purely combinational.
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [TW_W-1:0]    j,
    output logic [ADDR_W-1:0]  a,
    output logic [ADDR_W-1:0]  b,
    output logic [TW_W-1:0]    tw
);
    logic [ADDR_W-1:0] j_ext_s;
    logic [ADDR_W-1:0] span_s;
    logic [ADDR_W-1:0] pos_s;
    logic [ADDR_W-1:0] a_s;

    // Groups of 2*span lie back to back; pos selects the pair inside a group.
    always_comb begin
        j_ext_s = ADDR_W'(j);
        span_s  = ADDR_ONE << stage;
        pos_s   = j_ext_s & (span_s - ADDR_ONE);
        a_s     = ((j_ext_s >> stage) << ({1'b0, stage} + 3'd1)) + pos_s;
        a       = a_s;
        b       = a_s + span_s;
        tw      = TW_W'(pos_s) << (STAGE_LAST - stage);
    end
endmodule

// File: rtl/fft8_scheduler.sv
// Sequencer for an in-place radix-2 DIT FFT on one shared butterfly:
// issues butterflies stage by stage, then streams results to the SPI master.
module fft8_scheduler
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_ready,
    input  logic               bf_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               bf_start,
    output logic [ADDR_W-1:0]  bf_addr_a,
    output logic [ADDR_W-1:0]  bf_addr_b,
    output logic [TW_W-1:0]    bf_tw_idx,
    output logic               wr_en,
    output logic [STAGE_W-1:0] stage,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_dv,
    output logic               done,
    output logic               overrun
);
    state_e             state_r;
    state_e             state_next_s;
    logic [STAGE_W-1:0] stage_r;
    logic [STAGE_W-1:0] stage_next_s;
    logic [TW_W-1:0]    j_r;
    logic [TW_W-1:0]    j_next_s;
    logic [ADDR_W-1:0]  k_r;
    logic [ADDR_W-1:0]  k_next_s;
    logic               operand_hold_s;

    logic [ADDR_W-1:0]  gen_a_s;
    logic [ADDR_W-1:0]  gen_b_s;
    logic [TW_W-1:0]    gen_tw_s;

    logic               busy_r;
    logic               bf_start_r;
    logic               done_r;
    logic               overrun_r;
    logic [ADDR_W-1:0]  addr_a_r;
    logic [ADDR_W-1:0]  addr_b_r;
    logic [TW_W-1:0]    tw_r;

    // Operands are generated from the next (stage, j) so they register in
    // alignment with the ISSUE cycle.
    fft_addr_gen u_addr_gen (
        .stage (stage_next_s),
        .j     (j_next_s),
        .a     (gen_a_s),
        .b     (gen_b_s),
        .tw    (gen_tw_s)
    );

    // Next-state logic and butterfly / output-byte bookkeeping.
    always_comb begin
        state_next_s = state_r;
        stage_next_s = stage_r;
        j_next_s     = j_r;
        k_next_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_ready) begin
                    state_next_s = ST_ISSUE;
                    stage_next_s = {STAGE_W{1'b0}};
                    j_next_s     = {TW_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bf_valid) begin
                    state_next_s = ST_WAIT;
                end else if (j_r != J_LAST) begin
                    j_next_s     = j_r + TW_W'(1'b1);
                    state_next_s = ST_ISSUE;
                end else if (stage_r != STAGE_LAST) begin
                    j_next_s     = {TW_W{1'b0}};
                    stage_next_s = stage_r + STAGE_W'(1'b1);
                    state_next_s = ST_ISSUE;
                end else begin
                    k_next_s     = {ADDR_W{1'b0}};
                    state_next_s = ST_TX_PULSE;
                end
            end
            ST_TX_PULSE: begin
                if (tx_ready) begin
                    state_next_s = ST_TX_HOLD;
                end else begin
                    state_next_s = ST_TX_PULSE;
                end
            end
            ST_TX_HOLD: begin
                // The SPI master drops ready for a cycle after DV; ignore it here.
                state_next_s = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (!tx_ready) begin
                    state_next_s = ST_TX_WAIT;
                end else if (k_r != K_LAST) begin
                    k_next_s     = k_r + ADDR_ONE;
                    state_next_s = ST_TX_PULSE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operands are driven only while a butterfly is in flight.
    always_comb begin
        operand_hold_s = 1'b0;
        if ((state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT)) begin
            operand_hold_s = 1'b1;
        end else begin
            operand_hold_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            stage_r    <= {STAGE_W{1'b0}};
            j_r        <= {TW_W{1'b0}};
            k_r        <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            bf_start_r <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
            addr_a_r   <= {ADDR_W{1'b0}};
            addr_b_r   <= {ADDR_W{1'b0}};
            tw_r       <= {TW_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            stage_r    <= stage_next_s;
            j_r        <= j_next_s;
            k_r        <= k_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            bf_start_r <= (state_next_s == ST_ISSUE);
            done_r     <= (state_next_s == ST_DONE);
            overrun_r  <= overrun_r | (frame_ready & (state_r != ST_IDLE));
            if (operand_hold_s) begin
                addr_a_r <= gen_a_s;
                addr_b_r <= gen_b_s;
                tw_r     <= gen_tw_s;
            end else begin
                addr_a_r <= {ADDR_W{1'b0}};
                addr_b_r <= {ADDR_W{1'b0}};
                tw_r     <= {TW_W{1'b0}};
            end
        end
    end

    // Write-back and byte-valid must coincide with the handshake input itself.
    assign wr_en     = (state_r == ST_WAIT) & bf_valid;
    assign out_dv    = (state_r == ST_TX_PULSE) & tx_ready;
    assign busy      = busy_r;
    assign bf_start  = bf_start_r;
    assign done      = done_r;
    assign overrun   = overrun_r;
    assign bf_addr_a = addr_a_r;
    assign bf_addr_b = addr_b_r;
    assign bf_tw_idx = tw_r;
    assign stage     = stage_r;
    assign out_addr  = k_r;
endmodule

// File: tb/tb_fft8_scheduler.sv
// Self-checking bench for fft8_scheduler: randomized butterfly latencies and
// SPI ready gaps checked against a loop-built model of the FFT schedule.
module tb_fft8_scheduler;
    import fft_pkg::*;

    localparam int NBF = LOG2N * (N / 2);

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_ready;
    logic               bf_valid;
    logic               tx_ready;
    logic               busy;
    logic               bf_start;
    logic [ADDR_W-1:0]  bf_addr_a;
    logic [ADDR_W-1:0]  bf_addr_b;
    logic [TW_W-1:0]    bf_tw_idx;
    logic               wr_en;
    logic [STAGE_W-1:0] stage;
    logic [ADDR_W-1:0]  out_addr;
    logic               out_dv;
    logic               done;
    logic               overrun;

    int checks      = 0;
    int failures    = 0;
    int cyc_cnt     = 0;
    int wr_cnt      = 0;
    int start_cnt   = 0;
    int last_wr_cyc = 0;
    bit ovr_flag    = 1'b0;

    int exp_a  [NBF];
    int exp_b  [NBF];
    int exp_tw [NBF];
    int exp_st [NBF];

    fft8_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_ready (frame_ready),
        .bf_valid    (bf_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .bf_start    (bf_start),
        .bf_addr_a   (bf_addr_a),
        .bf_addr_b   (bf_addr_b),
        .bf_tw_idx   (bf_tw_idx),
        .wr_en       (wr_en),
        .stage       (stage),
        .out_addr    (out_addr),
        .out_dv      (out_dv),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt      <= wr_cnt + 1;
            last_wr_cyc <= cyc_cnt;
        end
        if (bf_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Schedule enumerated as stage -> group -> position within group.
    task automatic build_model();
        int idx;
        int span;
        idx = 0;
        for (int s = 0; s < LOG2N; s++) begin
            span = 1 << s;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    exp_a[idx]  = g * 2 * span + p;
                    exp_b[idx]  = g * 2 * span + p + span;
                    exp_tw[idx] = p * (N / (2 * span));
                    exp_st[idx] = s;
                    idx++;
                end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bf_start"}, bf_start, 0);
        chk({tag, "_a"}, bf_addr_a, 0);
        chk({tag, "_b"}, bf_addr_b, 0);
        chk({tag, "_tw"}, bf_tw_idx, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_out_addr"}, out_addr, 0);
        chk({tag, "_out_dv"}, out_dv, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // lat_fix/gap_fix of 0 mean random; rst_idx >= 0 aborts with reset in that butterfly's first WAIT.
    task automatic run_frame(input int lat_fix, input int gap_fix, input bit glitch,
                             input bit ovr, input bit done_pulse, input int rst_idx);
        int lat;
        int gap;
        int first_cyc;
        int exp_end;
        int wr0;
        int st0;
        wr0       = wr_cnt;
        st0       = start_cnt;
        exp_end   = 0;
        first_cyc = 0;
        step();
        frame_ready = 1'b1;
        bf_valid    = glitch;
        @(negedge clk);
        chk("launch_busy", busy, 0);
        chk("launch_wr_en", wr_en, 0);
        step();
        frame_ready = 1'b0;
        for (int i = 0; i < NBF; i++) begin
            @(negedge clk);
            chk("issue_bf_start", bf_start, 1);
            chk("issue_a", bf_addr_a, exp_a[i]);
            chk("issue_b", bf_addr_b, exp_b[i]);
            chk("issue_tw", bf_tw_idx, exp_tw[i]);
            chk("issue_stage", stage, exp_st[i]);
            chk("issue_wr_en", wr_en, 0);
            chk("issue_overrun", overrun, ovr_flag);
            if (i == 0) first_cyc = cyc_cnt;
            lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(4, 1));
            exp_end += 1 + lat;
            for (int w = 1; w <= lat; w++) begin
                step();
                bf_valid    = (w == lat);
                frame_ready = (ovr && i == 5 && w == 1);
                if (rst_idx == i && w == 1) begin
                    rst      = 1'b1;
                    bf_valid = 1'b1;
                    return;
                end
                @(negedge clk);
                chk("wait_wr_en", wr_en, (w == lat) ? 1 : 0);
                chk("wait_bf_start", bf_start, 0);
                chk("wait_a", bf_addr_a, exp_a[i]);
                chk("wait_b", bf_addr_b, exp_b[i]);
                chk("wait_tw", bf_tw_idx, exp_tw[i]);
                chk("wait_busy", busy, 1);
                if (frame_ready) ovr_flag = 1'b1;
            end
            step();
            bf_valid    = glitch;
            frame_ready = 1'b0;
        end
        chk("wr_en_count", wr_cnt - wr0, NBF);
        chk("bf_start_count", start_cnt - st0, NBF);
        chk("compute_end", last_wr_cyc, first_cyc + exp_end - 1);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("tx_out_dv", out_dv, 1);
            chk("tx_out_addr", out_addr, k);
            chk("tx_busy", busy, 1);
            chk("tx_overrun", overrun, ovr_flag);
            if (k == 0) chk("tx_start_cycle", cyc_cnt, first_cyc + exp_end);
            gap = (gap_fix != 0) ? gap_fix : int'($urandom_range(6, 1));
            for (int g = 0; g < gap; g++) begin
                step();
                tx_ready    = (g == 0) ? glitch : 1'b0;
                frame_ready = (ovr && k == 3 && g == 2);
                @(negedge clk);
                chk("gap_out_dv", out_dv, 0);
                chk("gap_out_addr", out_addr, k);
                chk("gap_done", done, 0);
                if (frame_ready) ovr_flag = 1'b1;
            end
            step();
            tx_ready    = 1'b1;
            frame_ready = 1'b0;
            @(negedge clk);
            chk("accept_out_dv", out_dv, 0);
            chk("accept_done", done, 0);
            step();
        end
        frame_ready = done_pulse;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_out_dv", out_dv, 0);
        if (done_pulse) ovr_flag = 1'b1;
        step();
        frame_ready = 1'b0;
        @(negedge clk);
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("after_overrun", overrun, ovr_flag);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_bf_start", bf_start, 0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_ready = 1'b0;
        bf_valid    = 1'b0;
        tx_ready    = 1'b1;
        build_model();
        @(negedge clk);
        chk_zero("reset_init");
        step();
        rst = 1'b0;
        repeat (2) step();

        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 1'b0, 1'b0, 1'b0, -1);
            repeat ($urandom_range(3, 0)) step();
        end

        step();
        bf_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_valid_wr_en", wr_en, 0);
            chk("idle_valid_busy", busy, 0);
            step();
        end
        run_frame(2, 20, 1'b1, 1'b0, 1'b1, -1);

        step();
        rst      = 1'b1;
        ovr_flag = 1'b0;
        @(negedge clk);
        chk("reset_clears_overrun", overrun, 0);
        step();
        rst = 1'b0;

        run_frame(0, 20, 1'b0, 1'b1, 1'b0, -1);

        run_frame(3, 2, 1'b0, 1'b0, 1'b0, 6);
        @(negedge clk);
        chk_zero("reset_mid_wait");
        ovr_flag = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_reset_wr_en", wr_en, 0);
            chk("post_reset_busy", busy, 0);
            chk("post_reset_bf_start", bf_start, 0);
            step();
        end
        bf_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
